// File: rtl/riscv_xstage_pkg.sv
// riscv_xstage_pkg: sequencer states and mul/div function codes for the execute stage.
package riscv_xstage_pkg;
   typedef enum logic [1:0] {IDLE, RUN, HOLD, DRAIN} state_t;
   typedef enum logic [2:0] {MUL = 3'd0, MULH, MULHSU, MULHU, MULW} mul_func_t;
   typedef enum logic [2:0] {DIV = 3'd0, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW} div_func_t;
endpackage

// File: rtl/riscv_fwd_muxn.sv
// riscv_fwd_muxn: selects the register-file operand or one of N packed forwarding sources.
module riscv_fwd_muxn #(
   parameter int W = 64,
   parameter int N = 3,
   localparam int SW = $clog2(N + 1)
) (
   input  logic [W-1:0]   rf,
   input  logic [N*W-1:0] fwd,
   input  logic [SW-1:0]  sel,
   output logic [W-1:0]   y
);
   // out-of-range selects fall through to the register file
   always_comb begin
      y = rf;
      for (int k = 0; k < N; k++)
         if (int'(sel) == k + 1) y = fwd[k*W +: W];
   end
endmodule

// File: rtl/riscv_xstage.sv
// riscv_xstage: RV64 execute-stage forwarding, E/M result register and mul/div sequencer.
// Define RISCV_XSTAGE_DIVZERO_BYPASS_EN to complete divides by zero locally in one cycle.
module riscv_xstage
   import riscv_xstage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int NFWD = 3,
   localparam int FW = $clog2(NFWD + 1)
) (
   input  logic             i_riscv_xstage_clk,
   input  logic             i_riscv_xstage_rst,
   input  logic             i_riscv_xstage_valid,
   input  logic             i_riscv_xstage_flush,
   input  logic             i_riscv_xstage_globstall,
   input  logic [XLEN-1:0]  i_riscv_xstage_rs1data,
   input  logic [XLEN-1:0]  i_riscv_xstage_rs2data,
   input  logic [NFWD*XLEN-1:0] i_riscv_xstage_fwd_data,
   input  logic [FW-1:0]    i_riscv_xstage_fwda,
   input  logic [FW-1:0]    i_riscv_xstage_fwdb,
   input  logic             i_riscv_xstage_oprnd1sel,
   input  logic             i_riscv_xstage_oprnd2sel,
   input  logic [XLEN-1:0]  i_riscv_xstage_pc,
   input  logic [XLEN-1:0]  i_riscv_xstage_simm,
   input  logic             i_riscv_xstage_mcop,
   input  logic             i_riscv_xstage_mcdiv,
   input  logic [2:0]       i_riscv_xstage_mcfunc,
   output logic [XLEN-1:0]  o_riscv_xstage_alu_opa,
   output logic [XLEN-1:0]  o_riscv_xstage_alu_opb,
   input  logic [XLEN-1:0]  i_riscv_xstage_alu_result,
   output logic             o_riscv_xstage_mc_start,
   output logic [XLEN-1:0]  o_riscv_xstage_mc_opa,
   output logic [XLEN-1:0]  o_riscv_xstage_mc_opb,
   output logic [3:0]       o_riscv_xstage_mc_func,
   input  logic             i_riscv_xstage_mc_done,
   input  logic [XLEN-1:0]  i_riscv_xstage_mc_result,
   output logic [XLEN-1:0]  o_riscv_xstage_store_data,
   output logic [XLEN-1:0]  o_riscv_xstage_result,
   output logic             o_riscv_xstage_result_valid,
   output logic             o_riscv_xstage_stall,
   output logic             o_riscv_xstage_busy
);
   state_t state, nxt;
   logic [XLEN-1:0] rs1f, rs2f, byp_val, done_val, hold_buf;
   logic bypass, take, alu_like, mc_real, launch, done_now, capture;
   logic globstall, flush, mc_done;

   assign globstall = i_riscv_xstage_globstall;
   assign flush = i_riscv_xstage_flush;
   assign mc_done = i_riscv_xstage_mc_done;

   riscv_fwd_muxn #(.W(XLEN), .N(NFWD)) u_fwda (
      .rf(i_riscv_xstage_rs1data), .fwd(i_riscv_xstage_fwd_data), .sel(i_riscv_xstage_fwda), .y(rs1f));
   riscv_fwd_muxn #(.W(XLEN), .N(NFWD)) u_fwdb (
      .rf(i_riscv_xstage_rs2data), .fwd(i_riscv_xstage_fwd_data), .sel(i_riscv_xstage_fwdb), .y(rs2f));

   assign o_riscv_xstage_alu_opa = i_riscv_xstage_oprnd1sel ? rs1f : i_riscv_xstage_pc;
   assign o_riscv_xstage_alu_opb = i_riscv_xstage_oprnd2sel ? i_riscv_xstage_simm : rs2f;
   assign o_riscv_xstage_store_data = rs2f;

`ifdef RISCV_XSTAGE_DIVZERO_BYPASS_EN
   logic is_word, is_rem;
   assign is_word = i_riscv_xstage_mcfunc inside {DIVW, DIVUW, REMW, REMUW};
   assign is_rem = i_riscv_xstage_mcfunc inside {REM, REMU, REMW, REMUW};
   assign bypass = i_riscv_xstage_mcop & i_riscv_xstage_mcdiv & (is_word ? rs2f[31:0] == '0 : rs2f == '0);
   assign byp_val = !is_rem ? '1 : is_word ? {{(XLEN-32){rs1f[31]}}, rs1f[31:0]} : rs1f;
`else
   assign bypass = 1'b0;
   assign byp_val = '0;
`endif

   assign take = i_riscv_xstage_valid & !flush;
   assign mc_real = i_riscv_xstage_mcop & !bypass;
   assign alu_like = !mc_real;
   assign capture = (state == RUN) & mc_done & globstall & !flush;

   always_comb begin
      nxt = state;
      launch = 1'b0;
      done_now = 1'b0;
      done_val = i_riscv_xstage_mcop ? byp_val : i_riscv_xstage_alu_result;
      o_riscv_xstage_stall = 1'b0;
      case (state)
         IDLE: begin
            done_now = take & alu_like;
            o_riscv_xstage_stall = take & mc_real;
            launch = take & mc_real & !globstall;
            nxt = launch ? RUN : IDLE;
         end
         RUN: begin
            done_now = mc_done & !flush & !globstall;
            done_val = i_riscv_xstage_mc_result;
            o_riscv_xstage_stall = !flush & !(mc_done & !globstall);
            nxt = flush ? (mc_done ? IDLE : DRAIN) : mc_done ? (globstall ? HOLD : IDLE) : RUN;
         end
         HOLD: begin
            done_now = !flush & !globstall;
            done_val = hold_buf;
            o_riscv_xstage_stall = !flush & globstall;
            nxt = (flush | !globstall) ? IDLE : HOLD;
         end
         default: begin
            // the killed op is still in the unit; later mul/div ops wait for it to retire
            done_now = take & alu_like;
            o_riscv_xstage_stall = take & mc_real;
            nxt = mc_done ? IDLE : DRAIN;
         end
      endcase
   end

   always_ff @(posedge i_riscv_xstage_clk or negedge i_riscv_xstage_rst) begin
      if (!i_riscv_xstage_rst) begin
         state <= IDLE;
         o_riscv_xstage_result <= '0;
         o_riscv_xstage_result_valid <= 1'b0;
         o_riscv_xstage_mc_start <= 1'b0;
         o_riscv_xstage_mc_opa <= '0;
         o_riscv_xstage_mc_opb <= '0;
         o_riscv_xstage_mc_func <= '0;
         hold_buf <= '0;
      end else begin
         state <= nxt;
         o_riscv_xstage_mc_start <= launch;
         if (launch) begin
            o_riscv_xstage_mc_opa <= rs1f;
            o_riscv_xstage_mc_opb <= rs2f;
            o_riscv_xstage_mc_func <= {i_riscv_xstage_mcdiv, i_riscv_xstage_mcfunc};
         end
         if (capture) hold_buf <= i_riscv_xstage_mc_result;
         if (!globstall) begin
            o_riscv_xstage_result_valid <= done_now;
            if (done_now) o_riscv_xstage_result <= done_val;
         end
      end
   end

   assign o_riscv_xstage_busy = state != IDLE;
endmodule

// File: tb/tb_riscv_xstage.sv
// tb_riscv_xstage: directed checks of forwarding, ALU path, mul/div sequencing, flush and reset.
module tb_riscv_xstage;
   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0, gs = 1'b0;
   logic o1 = 1'b0, o2 = 1'b0, mcop = 1'b0, mcdiv = 1'b0, mc_done = 1'b0;
   logic [63:0] rs1 = '0, rs2 = '0, pc = '0, simm = '0, mc_res = '0;
   logic [255:0] fwd;
   logic [2:0] fwda = '0, fwdb = '0, mcfunc = '0;
   logic [63:0] alu_opa, alu_opb, alu_res, mc_opa, mc_opb, store_data, result;
   logic [3:0] mc_func;
   logic mc_start, rv, stall, busy;
   int n_assert = 0, n_fail = 0, n;

   riscv_xstage #(.XLEN(64), .NFWD(4)) dut (
      .i_riscv_xstage_clk(clk), .i_riscv_xstage_rst(rst_n), .i_riscv_xstage_valid(valid),
      .i_riscv_xstage_flush(flush), .i_riscv_xstage_globstall(gs),
      .i_riscv_xstage_rs1data(rs1), .i_riscv_xstage_rs2data(rs2), .i_riscv_xstage_fwd_data(fwd),
      .i_riscv_xstage_fwda(fwda), .i_riscv_xstage_fwdb(fwdb),
      .i_riscv_xstage_oprnd1sel(o1), .i_riscv_xstage_oprnd2sel(o2),
      .i_riscv_xstage_pc(pc), .i_riscv_xstage_simm(simm),
      .i_riscv_xstage_mcop(mcop), .i_riscv_xstage_mcdiv(mcdiv), .i_riscv_xstage_mcfunc(mcfunc),
      .o_riscv_xstage_alu_opa(alu_opa), .o_riscv_xstage_alu_opb(alu_opb),
      .i_riscv_xstage_alu_result(alu_res),
      .o_riscv_xstage_mc_start(mc_start), .o_riscv_xstage_mc_opa(mc_opa), .o_riscv_xstage_mc_opb(mc_opb),
      .o_riscv_xstage_mc_func(mc_func), .i_riscv_xstage_mc_done(mc_done), .i_riscv_xstage_mc_result(mc_res),
      .o_riscv_xstage_store_data(store_data), .o_riscv_xstage_result(result),
      .o_riscv_xstage_result_valid(rv), .o_riscv_xstage_stall(stall), .o_riscv_xstage_busy(busy));

   assign alu_res = alu_opa + alu_opb;
   assign fwd = {64'h4444, 64'h3333, 64'h1234, 64'h1111};
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2;
      chk("rst_result", result, 0); chk("rst_rv", rv, 0); chk("rst_mc_start", mc_start, 0);
      chk("rst_busy", busy, 0); chk("rst_stall", stall, 0); chk("rst_mc_opa", mc_opa, 0);
      #10 rst_n = 1'b1;
      tick();
      // ALU path and forwarding
      valid = 1; fwda = 2; o1 = 1; o2 = 1; simm = 0; rs1 = 64'hAAAA; #1;
      chk("fwda2_opa", alu_opa, 64'h1234);
      tick(); chk("alu_fwd_result", result, 64'h1234); chk("alu_fwd_rv", rv, 1);
      fwda = 5; #1; chk("fwda5_opa", alu_opa, 64'hAAAA);
      tick(); chk("alu_rf_result", result, 64'hAAAA);
      fwda = 4; fwdb = 1; rs2 = 64'hBBBB; o2 = 0; #1;
      chk("fwda4_opa", alu_opa, 64'h4444); chk("fwdb1_opb", alu_opb, 64'h1111); chk("fwdb1_store", store_data, 64'h1111);
      fwdb = 7; #1; chk("fwdb7_store", store_data, 64'hBBBB); chk("fwdb7_opb", alu_opb, 64'hBBBB);
      o1 = 0; pc = 64'h8000; #1; chk("pc_opa", alu_opa, 64'h8000);
      tick(); chk("alu_pc_result", result, 64'h13BBB);
      fwda = 0; fwdb = 0; o1 = 1; rs1 = 64'h7; gs = 1;
      tick(); chk("gstall_freeze", result, 64'h13BBB); chk("gstall_rv", rv, 1);
      gs = 0; valid = 0;
      tick(); chk("invalid_rv", rv, 0); chk("invalid_hold", result, 64'h13BBB);
      valid = 1; flush = 1;
      tick(); chk("flush_rv", rv, 0);
      flush = 0;
      // MUL 3*5, unit completes 4 cycles after mc_start
      mcop = 1; mcdiv = 0; mcfunc = 0; rs1 = 3; rs2 = 5; o1 = 1; o2 = 0; #1;
      chk("mul_launch_stall", stall, 1); chk("mul_launch_start", mc_start, 0);
      n = 1;
      tick(); chk("mul_start", mc_start, 1); chk("mul_busy", busy, 1);
      chk("mul_opa", mc_opa, 3); chk("mul_opb", mc_opb, 5); chk("mul_func", mc_func, 0);
      if (stall) n++;
      repeat (3) begin tick(); if (stall) n++; end
      chk("mul_start_pulse", mc_start, 0);
      tick(); mc_done = 1; mc_res = 15; #1;
      chk("mul_done_stall", stall, 0); chk("mul_stall_cycles", n, 5);
      tick(); mc_done = 0; valid = 0; mcop = 0;
      chk("mul_result", result, 15); chk("mul_rv", rv, 1); chk("mul_idle", busy, 0);
      mc_done = 1; mc_res = 64'h77;
      tick(); mc_done = 0;
      chk("idle_done_busy", busy, 0); chk("idle_done_rv", rv, 0); chk("idle_done_result", result, 15);
      // DIVU completing under globstall -> HOLD
      valid = 1; mcop = 1; mcdiv = 1; mcfunc = 1; rs1 = 100; rs2 = 7;
      tick(); chk("divu_func", mc_func, 4'h9); chk("divu_start", mc_start, 1);
      tick(); mc_done = 1; mc_res = 14; gs = 1; #1; chk("hold_entry_stall", stall, 1);
      tick(); mc_done = 0;
      chk("hold_busy", busy, 1); chk("hold_stall", stall, 1); chk("hold_frozen", result, 15); chk("hold_rv", rv, 0);
      tick(); chk("hold_stall2", stall, 1);
      tick(); gs = 0; #1; chk("hold_release_stall", stall, 0);
      tick(); valid = 0; mcop = 0; mcdiv = 0;
      chk("hold_result", result, 14); chk("hold_result_rv", rv, 1); chk("hold_exit", busy, 0);
      // flush in RUN -> DRAIN, ADD proceeds, MUL in DRAIN waits
      valid = 1; mcop = 1; mcfunc = 4; rs1 = 6; rs2 = 7;
      tick();
      tick(); flush = 1; #1; chk("flush_run_stall", stall, 0);
      tick(); flush = 0; mcop = 0; o2 = 1; rs1 = 10; simm = 20; #1;
      chk("drain_busy", busy, 1); chk("drain_add_stall", stall, 0);
      tick(); chk("drain_add_result", result, 30); chk("drain_add_rv", rv, 1);
      mcop = 1; o2 = 0; rs1 = 2; rs2 = 9; #1; chk("drain_mul_stall", stall, 1);
      tick(); chk("drain_no_start", mc_start, 0); chk("drain_busy2", busy, 1);
      mc_done = 1; mc_res = 64'hDEAD; #1; chk("drain_done_stall", stall, 1);
      tick(); mc_done = 0;
      chk("drain_discard", result, 30); chk("drain_discard_rv", rv, 0); chk("drain_exit", busy, 0);
      tick(); chk("drain_mul_start", mc_start, 1); chk("drain_mul_opa", mc_opa, 2); chk("drain_mul_opb", mc_opb, 9);
      tick(); mc_done = 1; mc_res = 18;
      tick(); mc_done = 0; valid = 0; mcop = 0;
      chk("drain_mul_result", result, 18); chk("drain_mul_rv", rv, 1);
      // flush together with done in RUN -> IDLE
      valid = 1; mcop = 1; rs1 = 1; rs2 = 1;
      tick(); flush = 1; mc_done = 1; mc_res = 64'h99; #1; chk("flushdone_stall", stall, 0);
      tick(); flush = 0; mc_done = 0; valid = 0; mcop = 0;
      chk("flushdone_idle", busy, 0); chk("flushdone_rv", rv, 0); chk("flushdone_result", result, 18);
      // flush in HOLD discards the buffer
      valid = 1; mcop = 1;
      tick(); mc_done = 1; mc_res = 64'h55; gs = 1;
      tick(); mc_done = 0; flush = 1; #1; chk("flushhold_stall", stall, 0);
      tick(); flush = 0; gs = 0; valid = 0; mcop = 0; chk("flushhold_idle", busy, 0);
      tick(); chk("flushhold_rv", rv, 0); chk("flushhold_result", result, 18);
      // divide by zero
      valid = 1; mcop = 1; mcdiv = 1; mcfunc = 1; rs1 = 64'h55; rs2 = 0; o1 = 1; o2 = 0;
`ifdef RISCV_XSTAGE_DIVZERO_BYPASS_EN
      #1; chk("divz_stall", stall, 0);
      tick(); chk("divz_result", result, 64'hFFFF_FFFF_FFFF_FFFF); chk("divz_rv", rv, 1);
      chk("divz_no_start", mc_start, 0); chk("divz_busy", busy, 0);
      mcfunc = 6; rs1 = 64'h8000_0000; rs2 = 64'hFFFF_FFFF_0000_0000;
      tick(); chk("remw_result", result, 64'hFFFF_FFFF_8000_0000); chk("remw_no_start", mc_start, 0);
      valid = 0; mcop = 0; mcdiv = 0;
      tick();
`else
      #1; chk("divz_stall", stall, 1);
      tick(); chk("divz_start", mc_start, 1); chk("divz_busy", busy, 1);
      valid = 0; mcop = 0; mcdiv = 0; mc_done = 1; mc_res = 64'hFFFF_FFFF_FFFF_FFFF;
      tick(); mc_done = 0; chk("divz_result", result, 64'hFFFF_FFFF_FFFF_FFFF); chk("divz_rv", rv, 1);
`endif
      // asynchronous reset while RUN
      valid = 1; mcop = 1; mcdiv = 0; mcfunc = 0; rs1 = 64'h21; rs2 = 64'h3;
      tick(); valid = 0; mcop = 0;
      chk("pre_rst_start", mc_start, 1);
      #2 rst_n = 1'b0; #1;
      chk("arst_result", result, 0); chk("arst_rv", rv, 0); chk("arst_start", mc_start, 0);
      chk("arst_opa", mc_opa, 0); chk("arst_opb", mc_opb, 0); chk("arst_func", mc_func, 0);
      chk("arst_busy", busy, 0); chk("arst_stall", stall, 0);
      @(negedge clk); rst_n = 1'b1;
      mc_done = 1; mc_res = 64'h5;
      tick(); mc_done = 0;
      chk("stray_busy", busy, 0); chk("stray_rv", rv, 0); chk("stray_result", result, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
